mem_bus_if: RTL and testbench

MEM_BUS_IF -- requirements
Module: mem_bus_if

---
 rtl/mem_bus_if.sv | 128 ++++++++++++
 tb/tb_mem_bus_if.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mem_bus_if.sv
// rtl/mem_bus_if.sv - CPU data-port to single-cycle-ack external bus bridge
// Registers one bus cycle per access and stalls the pipeline until the ack.
module mem_bus_if (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_ce_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_data_i,
    input  logic [3:0]  cpu_sel_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq_o,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_data_o,
    output logic [3:0]  bus_sel_o,
    input  logic [31:0] bus_data_i,
    input  logic        bus_ack_i
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        BUSY       = 2'd1,
        WAIT_STALL = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_data_q, bus_data_d;
    logic [3:0]  bus_sel_q, bus_sel_d;
    logic [31:0] rd_buf_q, rd_buf_d;
    logic        stallreq;
    logic [31:0] cpu_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bus_req_q  <= 1'b0;
            bus_we_q   <= 1'b0;
            bus_addr_q <= 32'd0;
            bus_data_q <= 32'd0;
            bus_sel_q  <= 4'd0;
            rd_buf_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            bus_req_q  <= bus_req_d;
            bus_we_q   <= bus_we_d;
            bus_addr_q <= bus_addr_d;
            bus_data_q <= bus_data_d;
            bus_sel_q  <= bus_sel_d;
            rd_buf_q   <= rd_buf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bus_req_d  = bus_req_q;
        bus_we_d   = bus_we_q;
        bus_addr_d = bus_addr_q;
        bus_data_d = bus_data_q;
        bus_sel_d  = bus_sel_q;
        rd_buf_d   = rd_buf_q;
        stallreq   = 1'b0;
        cpu_data   = 32'd0;

        if (flush_i) begin
            // Flush wins over everything, including a coincident ack.
            state_d    = IDLE;
            bus_req_d  = 1'b0;
            bus_we_d   = 1'b0;
            bus_addr_d = 32'd0;
            bus_data_d = 32'd0;
            bus_sel_d  = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    stallreq = cpu_ce_i;
                    if (cpu_ce_i) begin
                        state_d    = BUSY;
                        bus_req_d  = 1'b1;
                        bus_we_d   = cpu_we_i;
                        bus_addr_d = cpu_addr_i;
                        bus_data_d = cpu_data_i;
                        bus_sel_d  = cpu_sel_i;
                    end
                end
                BUSY: begin
                    if (bus_ack_i) begin
                        cpu_data   = bus_data_i;
                        rd_buf_d   = bus_data_i;
                        bus_req_d  = 1'b0;
                        bus_we_d   = 1'b0;
                        bus_addr_d = 32'd0;
                        bus_data_d = 32'd0;
                        bus_sel_d  = 4'd0;
                        state_d    = (stall_i != 6'd0) ? WAIT_STALL : IDLE;
                    end else begin
                        stallreq = 1'b1;
                    end
                end
                WAIT_STALL: begin
                    // Hold the loaded word until the rest of the pipeline moves.
                    cpu_data = rd_buf_q;
                    if (stall_i == 6'd0) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign stallreq_o = stallreq & ~rst;
    assign cpu_data_o = rst ? 32'd0 : cpu_data;
    assign bus_req_o  = bus_req_q;
    assign bus_we_o   = bus_we_q;
    assign bus_addr_o = bus_addr_q;
    assign bus_data_o = bus_data_q;
    assign bus_sel_o  = bus_sel_q;

endmodule

// File: tb/tb_mem_bus_if.sv
// tb/tb_mem_bus_if.sv - directed vector bench for mem_bus_if
module tb_mem_bus_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_ce_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_data_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_o;
    logic        stallreq_o;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_data_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_data_i;
    logic        bus_ack_i;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_bus_if dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_ce_i   (cpu_ce_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_data_i (cpu_data_i),
        .cpu_sel_i  (cpu_sel_i),
        .cpu_data_o (cpu_data_o),
        .stallreq_o (stallreq_o),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .bus_req_o  (bus_req_o),
        .bus_we_o   (bus_we_o),
        .bus_addr_o (bus_addr_o),
        .bus_data_o (bus_data_o),
        .bus_sel_o  (bus_sel_o),
        .bus_data_i (bus_data_i),
        .bus_ack_i  (bus_ack_i)
    );

    // {stallreq, cpu_data, bus_req, bus_we, bus_addr, bus_data, bus_sel}
    logic [102:0] outs;
    assign outs = {stallreq_o, cpu_data_o, bus_req_o, bus_we_o, bus_addr_o, bus_data_o, bus_sel_o};

    typedef struct {
        logic         rst;
        logic         ce;
        logic         we;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        logic [3:0]   sel;
        logic [5:0]   stall;
        logic         flush;
        logic [31:0]  bdata;
        logic         ack;
        logic [102:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [102:0] ex(input logic sr, input logic [31:0] cd, input logic rq,
                                        input logic w, input logic [31:0] a, input logic [31:0] d,
                                        input logic [3:0] s);
        return {sr, cd, rq, w, a, d, s};
    endfunction

    function automatic vec_t mk(input logic r, input logic ce, input logic we, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [3:0] sel, input logic [5:0] st,
                                input logic fl, input logic [31:0] bd, input logic ack,
                                input logic [102:0] e);
        vec_t v;
        v.rst = r; v.ce = ce; v.we = we; v.addr = addr; v.wdata = wd; v.sel = sel;
        v.stall = st; v.flush = fl; v.bdata = bd; v.ack = ack; v.exp = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [102:0] act, input logic [102:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst        = v.rst;
        cpu_ce_i   = v.ce;
        cpu_we_i   = v.we;
        cpu_addr_i = v.addr;
        cpu_data_i = v.wdata;
        cpu_sel_i  = v.sel;
        stall_i    = v.stall;
        flush_i    = v.flush;
        bus_data_i = v.bdata;
        bus_ack_i  = v.ack;
    endtask

    localparam logic [102:0] Z = '0;

    initial begin
        vecs.push_back(mk(1,1,0,32'h0,0,4'hF,0,0,32'hDEADBEEF,1, Z));
        vecs.push_back(mk(0,0,0,32'h0,0,4'h0,0,0,32'hFFFFFFFF,1, Z));
        vecs.push_back(mk(0,1,0,32'h10,0,4'hF,0,0,32'h0,0, ex(1,0,0,0,0,0,0)));
        vecs.push_back(mk(0,1,0,32'h10,0,4'hF,0,0,32'h0,0, ex(1,0,1,0,32'h10,0,4'hF)));
        vecs.push_back(mk(0,1,0,32'h10,0,4'hF,0,0,32'h0,0, ex(1,0,1,0,32'h10,0,4'hF)));
        vecs.push_back(mk(0,1,0,32'h10,0,4'hF,0,0,32'hDEADBEEF,1, ex(0,32'hDEADBEEF,1,0,32'h10,0,4'hF)));
        vecs.push_back(mk(0,0,0,32'h0,0,4'h0,0,0,32'h0,0, Z));
        vecs.push_back(mk(0,1,1,32'h20,32'h12345678,4'h3,0,0,32'h0,0, ex(1,0,0,0,0,0,0)));
        vecs.push_back(mk(0,1,1,32'h20,32'h12345678,4'h3,0,0,32'h0000A5A5,1,
                          ex(0,32'h0000A5A5,1,1,32'h20,32'h12345678,4'h3)));
        vecs.push_back(mk(0,1,0,32'h30,0,4'hF,0,0,32'h0,0, ex(1,0,0,0,0,0,0)));
        vecs.push_back(mk(0,1,0,32'h30,0,4'hF,6'h07,0,32'hCAFEF00D,1, ex(0,32'hCAFEF00D,1,0,32'h30,0,4'hF)));
        vecs.push_back(mk(0,1,0,32'h30,0,4'hF,6'h07,0,32'h0,0, ex(0,32'hCAFEF00D,0,0,0,0,0)));
        vecs.push_back(mk(0,1,0,32'h30,0,4'hF,6'h07,0,32'h11111111,1, ex(0,32'hCAFEF00D,0,0,0,0,0)));
        vecs.push_back(mk(0,1,0,32'h30,0,4'hF,6'h07,0,32'h0,0, ex(0,32'hCAFEF00D,0,0,0,0,0)));
        vecs.push_back(mk(0,0,0,32'h0,0,4'h0,0,0,32'h0,0, ex(0,32'hCAFEF00D,0,0,0,0,0)));
        vecs.push_back(mk(0,0,0,32'h0,0,4'h0,0,0,32'h0,0, Z));
        vecs.push_back(mk(0,1,0,32'h40,0,4'h5,0,0,32'h0,0, ex(1,0,0,0,0,0,0)));
        vecs.push_back(mk(0,1,0,32'h40,0,4'h5,0,0,32'h0,0, ex(1,0,1,0,32'h40,0,4'h5)));
        vecs.push_back(mk(0,1,0,32'h40,0,4'h5,0,1,32'hBAD0BAD0,1, ex(0,0,1,0,32'h40,0,4'h5)));
        vecs.push_back(mk(0,0,0,32'h0,0,4'h0,0,0,32'h0,0, Z));
        vecs.push_back(mk(0,1,0,32'h70,0,4'hF,0,1,32'h0,0, Z));
        vecs.push_back(mk(0,0,0,32'h0,0,4'h0,0,0,32'h0,0, Z));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("vec%0d", i), outs, vecs[i].exp);
        end

        // Flushed ack must not have overwritten the buffered load word.
        n_run++;
        if (dut.rd_buf_q !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL rd_buf_after_flush: got %h expected %h", dut.rd_buf_q, 32'hCAFEF00D);
        end

        // Asynchronous reset in the middle of a BUSY cycle, then restart.
        @(negedge clk);
        drive(mk(0,1,0,32'h50,32'h0,4'hF,0,0,32'h0,0, Z));
        @(negedge clk);
        #1;
        chk("busy_before_rst", outs, ex(1,0,1,0,32'h50,0,4'hF));
        #2;
        rst = 1'b1;
        bus_ack_i = 1'b1;
        bus_data_i = 32'hFFFF0000;
        #1;
        chk("async_rst_outs", outs, Z);
        @(negedge clk);
        drive(mk(0,1,0,32'h60,32'h0,4'hC,0,0,32'h0,0, Z));
        #1;
        chk("post_rst_idle", outs, ex(1,0,0,0,0,0,0));
        @(negedge clk);
        #1;
        chk("post_rst_busy", outs, ex(1,0,1,0,32'h60,0,4'hC));
        bus_ack_i  = 1'b1;
        bus_data_i = 32'h00000012;
        #1;
        chk("post_rst_ack", outs, ex(0,32'h12,1,0,32'h60,0,4'hC));
        @(negedge clk);
        drive(mk(0,0,0,32'h0,0,4'h0,0,0,32'h0,0, Z));
        #1;
        chk("post_rst_done", outs, Z);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
